// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator (off / solid / blink / burst) on a 1 ms time base.
// Define LED_PATTERN_SYNC_EN to add sync_in, a global pattern/prescaler restart.
`timescale 1ns/1ps
module led_pattern_gen #(
  parameter int CLK_FREQ = 100000000,
  parameter int NUM_CH   = 4,
  parameter int HP_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LED_PATTERN_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [HP_W-1:0]   cfg_half_ms,
  input  logic [3:0]        cfg_burst_n,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led,
  output logic              ms_tick
);

  localparam int DIV   = CLK_FREQ / 1000;
  localparam int PRE_W = $clog2(DIV);
  localparam int CNT_W = HP_W + 2;  // holds 4*(2^HP_W-1) for the burst gap

  typedef enum logic [1:0] {MODE_OFF, MODE_SOLID, MODE_BLINK, MODE_BURST} mode_t;
  typedef enum logic [2:0] {ST_OFF, ST_SOLID, ST_ON, ST_LOW, ST_GAP} ch_state_t;

  function automatic ch_state_t start_state(input mode_t m, input logic [3:0] n);
    case (m)
      MODE_SOLID: return ST_SOLID;
      MODE_BLINK: return ST_ON;
      MODE_BURST: return (n == 4'd0) ? ST_OFF : ST_ON;
      default:    return ST_OFF;
    endcase
  endfunction

  logic [PRE_W-1:0] pre_q;
  logic             cfg_accept;
  logic             sync_hit;

  assign cfg_accept = cfg_valid && cfg_ready;
  assign ms_tick    = (pre_q == PRE_W'(DIV - 1));

`ifdef LED_PATTERN_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (sync_hit || ms_tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Ready drops for exactly the cycle following an accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !cfg_accept;
      cfg_err   <= cfg_accept && ({1'b0, cfg_ch} >= 5'(NUM_CH));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_t           mode_q, mode_d;
    logic [HP_W-1:0] half_q, half_d;
    logic [3:0]      burst_q, burst_d;
    logic [3:0]      pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_state_t       state_q, state_d;
    logic [CNT_W-1:0] hp_eff, last_half, last_gap;
    logic            wr_hit;

    assign wr_hit    = cfg_accept && (cfg_ch == 4'(i));
    assign hp_eff    = (half_q == '0) ? CNT_W'(1) : CNT_W'(half_q);
    assign last_half = hp_eff - 1'b1;
    assign last_gap  = (hp_eff << 2) - 1'b1;
    assign led[i]    = (state_q == ST_SOLID) || (state_q == ST_ON);

    // NOTE: every always_comb output is defaulted first so no latch can be inferred.
    always_comb begin
      mode_d  = mode_q;
      half_d  = half_q;
      burst_d = burst_q;
      pulse_d = pulse_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (wr_hit) begin
        mode_d  = mode_t'(cfg_mode);
        half_d  = cfg_half_ms;
        burst_d = cfg_burst_n;
        pulse_d = '0;
        cnt_d   = '0;
        state_d = start_state(mode_t'(cfg_mode), cfg_burst_n);
      end else if (sync_hit && (state_q inside {ST_ON, ST_LOW, ST_GAP})) begin
        pulse_d = '0;
        cnt_d   = '0;
        state_d = ST_ON;
      end else if (ms_tick) begin
        case (state_q)
          ST_ON: begin
            if (cnt_q == last_half) begin
              cnt_d   = '0;
              state_d = ST_LOW;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_LOW: begin
            if (cnt_q == last_half) begin
              cnt_d = '0;
              if (mode_q == MODE_BURST && pulse_q == burst_q - 4'd1) begin
                pulse_d = '0;
                state_d = ST_GAP;
              end else begin
                pulse_d = pulse_q + 4'd1;
                state_d = ST_ON;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt_q == last_gap) begin
              cnt_d   = '0;
              state_d = ST_ON;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q  <= MODE_OFF;
        half_q  <= HP_W'(500);
        burst_q <= '0;
        pulse_q <= '0;
        cnt_q   <= '0;
        state_q <= ST_OFF;
      end else begin
        mode_q  <= mode_d;
        half_q  <= half_d;
        burst_q <= burst_d;
        pulse_q <= pulse_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at 10 clk per ms; outputs sampled on the falling edge.
// Define LED_PATTERN_SYNC_EN for both files to include the sync_in scenario.
`timescale 1ns/1ps
module tb_led_pattern_gen;
  localparam int CLK_FREQ = 10000;
  localparam int NUM_CH   = 4;
  localparam int HP_W     = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [HP_W-1:0]   cfg_half_ms = '0;
  logic [3:0]        cfg_burst_n = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] led;
  logic              ms_tick;
`ifdef LED_PATTERN_SYNC_EN
  logic              sync_in = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_ref  = 0;

  led_pattern_gen #(.CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH), .HP_W(HP_W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef LED_PATTERN_SYNC_EN
    .sync_in     (sync_in),
`endif
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_mode    (cfg_mode),
    .cfg_half_ms (cfg_half_ms),
    .cfg_burst_n (cfg_burst_n),
    .cfg_err     (cfg_err),
    .led         (led),
    .ms_tick     (ms_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one write at a falling edge; returns on the falling edge after the accepting edge.
  task automatic wr(input logic [3:0] ch, input logic [1:0] mode,
                    input logic [HP_W-1:0] half, input logic [3:0] bn);
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_ch      = ch;
    cfg_mode    = mode;
    cfg_half_ms = half;
    cfg_burst_n = bn;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Count consecutive samples (starting with the current one) where led[ch] equals val.
  task automatic run_len(input int ch, input logic val, input int limit, output int n);
    n = 0;
    while (led[ch] === val && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Release reset and check ready timing, tick spacing and idle LEDs.
  task automatic release_and_check(input string tag);
    int first_tick = 0;
    int second_tick = 0;
    int led_bad = 0;
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_ready_rise: got %b expected 1", tag, cfg_ready);
        end
      end
      if (ms_tick === 1'b1) begin
        if (first_tick == 0) first_tick = k;
        else if (second_tick == 0) second_tick = k;
      end
      if (led !== 4'b0000) led_bad++;
    end
    checks++;
    if (first_tick != 9) begin
      errors++;
      $display("FAIL %s_first_tick: got sample %0d expected 9", tag, first_tick);
    end
    checks++;
    if (second_tick != 19) begin
      errors++;
      $display("FAIL %s_tick_period: got sample %0d expected 19", tag, second_tick);
    end
    checks++;
    if (led_bad != 0) begin
      errors++;
      $display("FAIL %s_led_idle: got %0d nonzero samples expected 0", tag, led_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({led, ms_tick, cfg_err, cfg_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {led, ms_tick, cfg_err, cfg_ready});
    end
    release_and_check("reset");
  endtask

  task automatic test_blink();
    int n;
    wr(4'd0, 2'b10, 12'd3, 4'd0);
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_write: got %b expected 0", cfg_ready);
    end
    checks++;
    if (led[0] !== 1'b1) begin
      errors++;
      $display("FAIL blink_start: got %b expected 1", led[0]);
    end
    run_len(0, 1'b1, 40, n);
    checks++;
    if (n < 21 || n > 30) begin
      errors++;
      $display("FAIL blink_first_on: got %0d expected 21..30", n);
    end
    t_ref = cyc;
    run_len(0, 1'b0, 80, n);
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL blink_low: got %0d expected 30", n);
    end
    run_len(0, 1'b1, 80, n);
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL blink_high: got %0d expected 30", n);
    end
    run_len(0, 1'b0, 80, n);
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL blink_low2: got %0d expected 30", n);
    end
  endtask

  task automatic test_burst();
    int n;
    int ones;
    int exp_run [7];
    exp_run = '{10, 10, 50, 10, 10, 10, 50};
    wr(4'd1, 2'b11, 12'd1, 4'd2);
    checks++;
    if (led[1] !== 1'b1) begin
      errors++;
      $display("FAIL burst_start: got %b expected 1", led[1]);
    end
    run_len(1, 1'b1, 20, n);
    checks++;
    if (n < 1 || n > 10) begin
      errors++;
      $display("FAIL burst_first_on: got %0d expected 1..10", n);
    end
    for (int i = 0; i < 7; i++) begin
      run_len(1, (i % 2 == 0) ? 1'b0 : 1'b1, 80, n);
      checks++;
      if (n != exp_run[i]) begin
        errors++;
        $display("FAIL burst_run%0d: got %0d expected %0d", i, n, exp_run[i]);
      end
    end
    wr(4'd1, 2'b11, 12'd1, 4'd0);
    ones = 0;
    for (int k = 0; k < 30; k++) begin
      if (led[1] !== 1'b0) ones++;
      @(negedge clk);
    end
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL burst_zero_off: got %0d high samples expected 0", ones);
    end
  endtask

  task automatic test_err();
    wr(4'd5, 2'b01, 12'd1, 4'd0);
    checks++;
    if (cfg_err !== 1'b1 || led[3:1] !== 3'b000) begin
      errors++;
      $display("FAIL err_pulse: got err=%b led[3:1]=%b expected err=1 led[3:1]=000", cfg_err, led[3:1]);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || led[3:1] !== 3'b000) begin
      errors++;
      $display("FAIL err_width: got err=%b led[3:1]=%b expected err=0 led[3:1]=000", cfg_err, led[3:1]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_ch    = 4'd2;
    cfg_mode  = 2'b01;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0 || led[2] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got ready=%b led2=%b expected ready=0 led2=1", cfg_ready, led[2]);
    end
    cfg_ch = 4'd3;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || led[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait: got ready=%b led3=%b expected ready=1 led3=0", cfg_ready, led[3]);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0 || led[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got ready=%b led3=%b expected ready=0 led3=1", cfg_ready, led[3]);
    end
  endtask

  task automatic test_tick_collision();
    int n;
    int guard = 0;
    @(negedge clk);
    while (ms_tick !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (ms_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_wait: got ms_tick=%b expected 1 within 20 cycles", ms_tick);
    end
    cfg_valid   = 1'b1;
    cfg_ch      = 4'd2;
    cfg_mode    = 2'b10;
    cfg_half_ms = 12'd0;
    cfg_burst_n = 4'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    run_len(2, 1'b1, 40, n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL collide_first_on: got %0d expected 10", n);
    end
    run_len(2, 1'b0, 40, n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL half0_low: got %0d expected 10", n);
    end
    run_len(2, 1'b1, 40, n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL half0_high: got %0d expected 10", n);
    end
  endtask

  task automatic test_independence();
    int n;
    if (led[0] === 1'b0) run_len(0, 1'b0, 80, n);
    run_len(0, 1'b1, 80, n);
    checks++;
    if (((cyc - t_ref) % 60) != 0) begin
      errors++;
      $display("FAIL ch0_phase: got offset %0d expected multiple of 60", cyc - t_ref);
    end
  endtask

  task automatic test_reset_mid();
    wr(4'd1, 2'b11, 12'd1, 4'd2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000 || ms_tick !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got led=%b tick=%b err=%b expected 0000/0/0", led, ms_tick, cfg_err);
    end
    @(negedge clk);
    release_and_check("reset_mid");
  endtask

`ifdef LED_PATTERN_SYNC_EN
  task automatic test_sync();
    int n;
    int guard = 0;
    wr(4'd0, 2'b10, 12'd3, 4'd0);
    wr(4'd2, 2'b10, 12'd2, 4'd0);
    wr(4'd3, 2'b01, 12'd1, 4'd0);
    while (led[0] !== 1'b0 && guard < 80) begin
      guard++;
      @(negedge clk);
    end
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    checks++;
    if (led !== 4'b1101) begin
      errors++;
      $display("FAIL sync_restart: got %b expected 1101", led);
    end
    run_len(2, 1'b1, 50, n);
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL sync_prescaler: got %0d expected 20", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_err();
    test_back_to_back();
    test_tick_collision();
    test_independence();
    test_reset_mid();
`ifdef LED_PATTERN_SYNC_EN
    test_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
